// File: rtl/fighter_pkg.sv
// Shared constants and types for the fighter game's per-player movement logic.
// Positions are screen coordinates with y growing downward.
package fighter_pkg;

   localparam int POS_WIDTH = 10;

   localparam int X_START  = 100;
   localparam int Y_GROUND = 400;
   localparam int X_MIN    = 0;
   localparam int X_MAX    = 600;

   localparam int PLAYER_W = 40;
   localparam int STEP     = 4;
   localparam int JUMP_V0  = 16;
   localparam int GRAVITY  = 1;

   typedef enum logic {
      GROUND = 1'b0,
      AIR    = 1'b1
   } jump_state_e;

endpackage : fighter_pkg

// File: rtl/player_move_if.sv
// Command and status bundle between the action decoder and one player's
// movement controller; the renderer and collision logic read the status side.
interface player_move_if #(
   parameter int W = fighter_pkg::POS_WIDTH
) ();
   import fighter_pkg::*;

   // No valid/ready pair: commands are levels sampled only on clk edges with
   // SCEN=1, and the controller always accepts them (no backpressure).
   logic         SCEN;
   logic         move_enable;
   logic         move_left;
   logic         move_right;
   logic         jump;
   logic [W-1:0] opponent_x;

   logic [W-1:0] pos_x;
   logic [W-1:0] pos_y;
   logic         x_lock;
   logic         facing_right;
   logic         move_active;
   logic         jump_active;
   jump_state_e  jump_state;

   modport master (
      output SCEN, move_enable, move_left, move_right, jump, opponent_x,
      input  pos_x, pos_y, x_lock, facing_right, move_active, jump_active,
             jump_state
   );

   modport slave (
      input  SCEN, move_enable, move_left, move_right, jump, opponent_x,
      output pos_x, pos_y, x_lock, facing_right, move_active, jump_active,
             jump_state
   );

endinterface : player_move_if

// File: rtl/player_jump.sv
// Vertical integrator for one player: ground/air state machine, signed
// velocity and pos_y, advanced once per frame tick.
module player_jump
   import fighter_pkg::*;
#(
   parameter int POS_WIDTH = fighter_pkg::POS_WIDTH,
   parameter int Y_GROUND  = fighter_pkg::Y_GROUND,
   parameter int JUMP_V0   = fighter_pkg::JUMP_V0,
   parameter int GRAVITY   = fighter_pkg::GRAVITY
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 scen,
   input  logic                 jump_req,
   output logic [POS_WIDTH-1:0] pos_y,
   output logic                 jump_active,
   output jump_state_e          state
);

   // Two guard bits: one for the unsigned-to-signed move, one so that
   // pos_y minus a negative velocity cannot wrap.
   localparam int YW = POS_WIDTH + 2;

   localparam logic [POS_WIDTH-1:0]        Y_GROUND_V = POS_WIDTH'(Y_GROUND);
   localparam logic [POS_WIDTH-1:0]        Y_LAUNCH   = POS_WIDTH'(Y_GROUND - JUMP_V0);
   localparam logic signed [POS_WIDTH-1:0] V_LAUNCH   = POS_WIDTH'(JUMP_V0 - GRAVITY);
   localparam logic signed [POS_WIDTH-1:0] GRAV_V     = POS_WIDTH'(GRAVITY);
   localparam logic signed [YW-1:0]        Y_GROUND_X = YW'(Y_GROUND);

   jump_state_e                   state_q, state_d;
   logic [POS_WIDTH-1:0]          pos_y_q, pos_y_d;
   logic signed [POS_WIDTH-1:0]   vel_q, vel_d;
   logic signed [YW-1:0]          y_next;

   always_comb begin
      y_next = $signed({2'b00, pos_y_q}) - $signed({{2{vel_q[POS_WIDTH-1]}}, vel_q});
   end

   always_comb begin
      state_d = state_q;
      pos_y_d = pos_y_q;
      vel_d   = vel_q;
      if (scen) begin
         case (state_q)
            GROUND: begin
               if (jump_req) begin
                  state_d = AIR;
                  pos_y_d = Y_LAUNCH;
                  vel_d   = V_LAUNCH;
               end
            end
            AIR: begin
               if (y_next >= Y_GROUND_X) begin
                  state_d = GROUND;
                  pos_y_d = Y_GROUND_V;
                  vel_d   = '0;
               end else begin
                  pos_y_d = y_next[POS_WIDTH-1:0];
                  vel_d   = vel_q - GRAV_V;
               end
            end
            default: begin
               state_d = GROUND;
               pos_y_d = Y_GROUND_V;
               vel_d   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= GROUND;
         pos_y_q <= Y_GROUND_V;
         vel_q   <= '0;
      end else begin
         state_q <= state_d;
         pos_y_q <= pos_y_d;
         vel_q   <= vel_d;
      end
   end

   assign pos_y       = pos_y_q;
   assign jump_active = (state_q == AIR);
   assign state       = state_q;

endmodule : player_jump

// File: rtl/player_move.sv
// Per-player movement controller: walks within the arena without overlapping
// the opponent, tracks facing, and delegates the vertical motion to player_jump.
module player_move
   import fighter_pkg::*;
#(
   parameter int POS_WIDTH = fighter_pkg::POS_WIDTH,
   parameter int X_START   = fighter_pkg::X_START,
   parameter int Y_GROUND  = fighter_pkg::Y_GROUND,
   parameter int X_MIN     = fighter_pkg::X_MIN,
   parameter int X_MAX     = fighter_pkg::X_MAX,
   parameter int PLAYER_W  = fighter_pkg::PLAYER_W,
   parameter int STEP      = fighter_pkg::STEP,
   parameter int JUMP_V0   = fighter_pkg::JUMP_V0,
   parameter int GRAVITY   = fighter_pkg::GRAVITY
) (
   input logic          clk,
   input logic          reset,
   player_move_if.slave bus
);

   // One extra bit keeps every sum and difference of positions free of wrap.
   localparam int E = POS_WIDTH + 1;

   localparam logic [E-1:0] STEP_E  = E'(STEP);
   localparam logic [E-1:0] X_MIN_E = E'(X_MIN);
   localparam logic [E-1:0] X_MAX_E = E'(X_MAX);
   localparam logic [E-1:0] PW_E    = E'(PLAYER_W);

   logic [POS_WIDTH-1:0] pos_x_q, pos_x_d;
   logic                 facing_q, facing_d;
   logic                 move_active_q, move_active_d;

   logic [E-1:0] px, ox, tgt, lim;
   logic         x_lock;
   logic         jump_req;

   logic [POS_WIDTH-1:0] pos_y;
   logic                 jump_active;
   jump_state_e          jump_state;

   assign px = {1'b0, pos_x_q};
   assign ox = {1'b0, bus.opponent_x};

   always_comb begin
      x_lock = facing_q ? (px + PW_E >= ox) : (px <= ox + PW_E);
   end

   always_comb begin
      pos_x_d       = pos_x_q;
      facing_d      = facing_q;
      move_active_d = move_active_q;
      tgt           = px;
      lim           = '0;
      if (bus.SCEN) begin
         if (ox > px) begin
            facing_d = 1'b1;
         end else if (ox < px) begin
            facing_d = 1'b0;
         end

         if (bus.move_enable && (bus.move_right != bus.move_left)) begin
            if (bus.move_right) begin
               tgt = (px + STEP_E > X_MAX_E) ? X_MAX_E : px + STEP_E;
               // Opponent clamp only on the facing side; it may stop us but never push us back.
               if (facing_q) begin
                  lim = (ox >= PW_E) ? ox - PW_E : '0;
                  if (tgt > lim) tgt = lim;
                  if (tgt < px)  tgt = px;
               end
            end else begin
               tgt = (px >= X_MIN_E + STEP_E) ? px - STEP_E : X_MIN_E;
               if (!facing_q) begin
                  lim = ox + PW_E;
                  if (tgt < lim) tgt = lim;
                  if (tgt > px)  tgt = px;
               end
            end
         end

         pos_x_d       = tgt[POS_WIDTH-1:0];
         move_active_d = (tgt != px);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pos_x_q       <= POS_WIDTH'(X_START);
         facing_q      <= 1'b1;
         move_active_q <= 1'b0;
      end else begin
         pos_x_q       <= pos_x_d;
         facing_q      <= facing_d;
         move_active_q <= move_active_d;
      end
   end

   assign jump_req = bus.move_enable & bus.jump;

   player_jump #(
      .POS_WIDTH (POS_WIDTH),
      .Y_GROUND  (Y_GROUND),
      .JUMP_V0   (JUMP_V0),
      .GRAVITY   (GRAVITY)
   ) u_jump (
      .clk         (clk),
      .reset       (reset),
      .scen        (bus.SCEN),
      .jump_req    (jump_req),
      .pos_y       (pos_y),
      .jump_active (jump_active),
      .state       (jump_state)
   );

   assign bus.pos_x        = pos_x_q;
   assign bus.pos_y        = pos_y;
   assign bus.x_lock       = x_lock;
   assign bus.facing_right = facing_q;
   assign bus.move_active  = move_active_q;
   assign bus.jump_active  = jump_active;
   assign bus.jump_state   = jump_state;

endmodule : player_move

// File: tb/tb_player_move.sv
// Self-checking bench for player_move: directed walk/jump/clamp scenarios
// followed by random ticks, all scored against a small behavioural model.
module tb_player_move;
   import fighter_pkg::*;

   localparam int W = POS_WIDTH;

   typedef struct packed {
      logic [W-1:0] x;
      logic [W-1:0] y;
      logic         face;
      logic         mact;
      logic         jact;
      logic         lock;
   } exp_t;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   player_move_if bus ();

   player_move dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard ----------------
   int   n_cmp = 0;
   int   n_err = 0;
   exp_t exp_q[$];

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // ---------------- reference model ----------------
   int m_x, m_y, m_t, m_face, m_mact, m_air;

   function automatic void model_reset();
      m_x = X_START; m_y = Y_GROUND; m_t = 0;
      m_face = 1; m_mact = 0; m_air = 0;
   endfunction

   function automatic bit model_lock(input int opp);
      return m_face != 0 ? (m_x + PLAYER_W >= opp) : (m_x <= opp + PLAYER_W);
   endfunction

   function automatic void model_tick(input bit en, input bit l, input bit r, input bit j,
                                      input int opp);
      int nx, lim, nface;
      nface = m_face;
      if (opp > m_x) nface = 1;
      else if (opp < m_x) nface = 0;
      nx = m_x;
      if (en && (l != r)) begin
         if (r) begin
            nx = m_x + STEP;
            if (nx > X_MAX) nx = X_MAX;
            if (m_face != 0) begin
               lim = opp - PLAYER_W;
               if (lim < 0) lim = 0;
               if (nx > lim) nx = lim;
               if (nx < m_x) nx = m_x;
            end
         end else begin
            nx = m_x - STEP;
            if (nx < X_MIN) nx = X_MIN;
            if (m_face == 0) begin
               lim = opp + PLAYER_W;
               if (nx < lim) nx = lim;
               if (nx > m_x) nx = m_x;
            end
         end
      end
      m_mact = (nx != m_x) ? 1 : 0;
      m_x    = nx;
      m_face = nface;
      // Height follows the closed-form ballistic curve from the launch tick.
      if (m_air != 0) begin
         m_t++;
         m_y = Y_GROUND - (JUMP_V0 * m_t - GRAVITY * m_t * (m_t - 1) / 2);
         if (m_y >= Y_GROUND) begin
            m_y = Y_GROUND; m_air = 0; m_t = 0;
         end
      end else if (en && j) begin
         m_air = 1; m_t = 1; m_y = Y_GROUND - JUMP_V0;
      end
   endfunction

   // ---------------- driver ----------------
   task automatic drive_tick(input bit scen, input bit en, input bit l, input bit r,
                             input bit j, input int opp);
      exp_t e;
      bus.SCEN        = scen;
      bus.move_enable = en;
      bus.move_left   = l;
      bus.move_right  = r;
      bus.jump        = j;
      bus.opponent_x  = W'(opp);
      @(posedge clk);
      if (scen) model_tick(en, l, r, j, opp);
      e.x    = W'(m_x);
      e.y    = W'(m_y);
      e.face = (m_face != 0);
      e.mact = (m_mact != 0);
      e.jact = (m_air != 0);
      e.lock = model_lock(opp);
      exp_q.push_back(e);
      @(negedge clk);
      e = exp_q.pop_front();
      check_eq("pos_x",        32'(bus.pos_x),        32'(e.x));
      check_eq("pos_y",        32'(bus.pos_y),        32'(e.y));
      check_eq("facing_right", 32'(bus.facing_right), 32'(e.face));
      check_eq("move_active",  32'(bus.move_active),  32'(e.mact));
      check_eq("jump_active",  32'(bus.jump_active),  32'(e.jact));
      check_eq("jump_state",   32'(bus.jump_state),   32'(e.jact));
      check_eq("x_lock",       32'(bus.x_lock),       32'(e.lock));
   endtask

   // ---------------- stimulus ----------------
   initial begin
      reset           = 1'b0;
      bus.SCEN        = 1'b0;
      bus.move_enable = 1'b0;
      bus.move_left   = 1'b0;
      bus.move_right  = 1'b0;
      bus.jump        = 1'b0;
      bus.opponent_x  = W'(200);
      model_reset();
      repeat (3) @(negedge clk);
      check_eq("rst_pos_x",  32'(bus.pos_x),        100);
      check_eq("rst_pos_y",  32'(bus.pos_y),        400);
      check_eq("rst_facing", 32'(bus.facing_right), 1);
      check_eq("rst_jact",   32'(bus.jump_active),  0);
      check_eq("rst_mact",   32'(bus.move_active),  0);
      check_eq("rst_xlock",  32'(bus.x_lock),       0);
      reset = 1'b1;

      // Walk right into the opponent, then step back.
      repeat (5) drive_tick(1, 1, 0, 1, 0, 200);
      check_eq("walk5_x",    32'(bus.pos_x),       120);
      check_eq("walk5_mact", 32'(bus.move_active), 1);
      repeat (12) drive_tick(1, 1, 0, 1, 0, 200);
      check_eq("block_x",     32'(bus.pos_x),       160);
      check_eq("block_xlock", 32'(bus.x_lock),      1);
      check_eq("block_mact",  32'(bus.move_active), 0);
      drive_tick(1, 1, 1, 0, 0, 200);
      check_eq("back_x", 32'(bus.pos_x), 156);

      // Full jump with jump held throughout, then retrigger after landing.
      drive_tick(1, 1, 0, 0, 1, 200);
      check_eq("launch_y",    32'(bus.pos_y),       384);
      check_eq("launch_jact", 32'(bus.jump_active), 1);
      repeat (15) drive_tick(1, 1, 0, 0, 1, 200);
      check_eq("apex_y", 32'(bus.pos_y), 264);
      repeat (17) drive_tick(1, 1, 0, 0, 1, 200);
      check_eq("land_y",    32'(bus.pos_y),       400);
      check_eq("land_jact", 32'(bus.jump_active), 0);
      drive_tick(1, 1, 0, 0, 1, 200);
      check_eq("retrig_y", 32'(bus.pos_y), 384);
      repeat (5) drive_tick(1, 1, 0, 0, 0, 200);
      check_eq("air6_y", 32'(bus.pos_y), 319);

      // Frame enable low freezes everything mid-jump.
      repeat (4) drive_tick(0, 1, 0, 1, 1, 200);
      check_eq("frozen_y", 32'(bus.pos_y), 319);
      check_eq("frozen_x", 32'(bus.pos_x), 156);

      // Asynchronous reset mid-jump lands the player immediately.
      #2 reset = 1'b0;
      #1;
      check_eq("midrst_y",    32'(bus.pos_y),       400);
      check_eq("midrst_jact", 32'(bus.jump_active), 0);
      check_eq("midrst_x",    32'(bus.pos_x),       100);
      model_reset();
      @(negedge clk);
      reset = 1'b1;

      // Opponent clamp to 102, then walk left into the arena edge.
      drive_tick(1, 1, 0, 1, 0, 142);
      check_eq("clamp102_x", 32'(bus.pos_x), 102);
      repeat (30) drive_tick(1, 1, 1, 0, 0, 500);
      check_eq("edge_x",    32'(bus.pos_x),       0);
      check_eq("edge_mact", 32'(bus.move_active), 0);

      // Both directions at once is no move.
      repeat (3) drive_tick(1, 1, 0, 1, 0, 500);
      drive_tick(1, 1, 1, 1, 0, 500);
      check_eq("both_x",    32'(bus.pos_x),       12);
      check_eq("both_mact", 32'(bus.move_active), 0);

      // move_enable low blocks walk and jump; SCEN low blocks everything.
      drive_tick(1, 0, 0, 1, 1, 500);
      check_eq("noen_x",    32'(bus.pos_x),       12);
      check_eq("noen_jact", 32'(bus.jump_active), 0);
      drive_tick(0, 1, 0, 1, 1, 500);
      check_eq("noscen_x",    32'(bus.pos_x),       12);
      check_eq("noscen_jact", 32'(bus.jump_active), 0);

      // Random ticks with the opponent mostly close by.
      repeat (400) begin
         int  o;
         bit  sc, en, l, r, j;
         sc = ($urandom_range(0, 9) != 0);
         en = ($urandom_range(0, 7) != 0);
         l  = 1'($urandom_range(0, 1));
         r  = 1'($urandom_range(0, 1));
         j  = ($urandom_range(0, 5) == 0);
         if ($urandom_range(0, 9) == 0) o = int'($urandom_range(0, 1023));
         else o = m_x + int'($urandom_range(0, 120)) - 60;
         if (o < 0) o = 0;
         if (o > 1023) o = 1023;
         drive_tick(sc, en, l, r, j, o);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule : tb_player_move

// File: doc/player_move.md
Name: player_move

Overview:
- Per-player movement controller for the fighter game.
- Holds the player's screen position (pos_x, pos_y) and integrates walk and jump inputs once per frame tick (SCEN).
- Prevents the player overlapping the opponent and tracks facing direction.
- Sits between the input/action decoder and the sprite renderer/collision logic.

Parameters:
- POS_WIDTH, 10, bit width of all position buses.
- X_START, 100, reset x position.
- Y_GROUND, 400, ground y position (screen coordinates, y grows downward).
- X_MIN, 0, left arena bound.
- X_MAX, 600, right arena bound for pos_x.
- PLAYER_W, 40, player body width; minimum x separation to the opponent.
- STEP, 4, horizontal pixels moved per tick.
- JUMP_V0, 16, initial upward velocity in px/tick.
- GRAVITY, 1, velocity decrement per tick.

Ports:
- clk, in, 1, system clock.
- reset, in, 1, asynchronous active-low reset.
- SCEN, in, 1, frame-tick enable; all state updates only on clk edges with SCEN=1.
- move_enable, in, 1, permits new walk/jump commands.
- move_left, in, 1, walk left request.
- move_right, in, 1, walk right request.
- jump, in, 1, jump request (level).
- opponent_x, in, POS_WIDTH, opponent's x position.
- pos_x, out, POS_WIDTH, player x (registered).
- pos_y, out, POS_WIDTH, player y (registered).
- x_lock, out, 1, player is touching the opponent on the facing side (combinational).
- facing_right, out, 1, opponent is to the right (registered).
- move_active, out, 1, x changed on the last tick (registered).
- jump_active, out, 1, airborne (registered).

Behaviour:
- Reset (reset=0, asynchronous) sets: pos_x=X_START, pos_y=Y_GROUND, facing_right=1, move_active=0, jump_active=0, velocity=0.
  - Reset asserted mid-jump returns the player to the ground immediately.
- SCEN=0: all registers hold.
- Arithmetic: all comparisons and sums use POS_WIDTH+1 bits, so there is no wrap. Velocity is a signed register of POS_WIDTH bits.
- facing_right, updated per tick from the pre-update position:
  - opponent_x > pos_x gives 1.
  - opponent_x < pos_x gives 0.
  - Equal: hold.
- x_lock, combinational from current registers:
  - facing_right=1: asserted when pos_x + PLAYER_W >= opponent_x.
  - facing_right=0: asserted when pos_x <= opponent_x + PLAYER_W.
- Horizontal motion, per tick with move_enable=1. Both or neither of move_left/move_right means no move.
  - move_right:
    - Target = pos_x + STEP.
    - Clamp to X_MAX.
    - If facing_right, also clamp to opponent_x - PLAYER_W, and never move left as a result of that clamp.
  - move_left:
    - Target = pos_x - STEP.
    - Clamp to X_MIN. No underflow: pos_x < STEP gives X_MIN.
    - If !facing_right, also clamp to opponent_x + PLAYER_W, and never move right as a result of that clamp.
  - Movement away from the opponent is always allowed while x_lock=1.
  - Horizontal motion is allowed while airborne.
- move_active: set to 1 on a tick when pos_x changes, otherwise 0; held between ticks.
- Jump, with two states, GROUND and AIR:
  - GROUND to AIR on a tick with jump=1, move_enable=1, jump_active=0. On that tick: velocity=JUMP_V0-GRAVITY, pos_y=Y_GROUND-JUMP_V0, jump_active=1.
  - Each AIR tick: pos_y = pos_y - velocity, then velocity = velocity - GRAVITY.
  - If the new pos_y >= Y_GROUND, clamp pos_y to Y_GROUND, set velocity=0, jump_active=0 (return to GROUND).
  - With defaults: apex pos_y=264 reached after tick 16; landing after tick 33.
  - A held jump does not retrigger while airborne. It retriggers on the first tick after landing if still held.
  - move_enable=0 blocks new walk/jump commands but an in-progress jump continues.
- opponent_x changes mid-move take effect on the next tick. No bound checking is done on opponent_x.

Decomposition:
- Shared package (fighter_pkg) holds:
  - POS_WIDTH;
  - arena bounds X_MIN, X_MAX, Y_GROUND;
  - PLAYER_W, STEP, JUMP_V0, GRAVITY;
  - AIR/GROUND state encoding.
- One natural sub-module: player_jump, which holds the vertical velocity/pos_y integrator and the jump state machine.
- Horizontal motion and lock logic stay in player_move.

Test Plan:
- Reset with opponent_x=200, then release -> pos_x=100, pos_y=400, facing_right=1, jump_active=0, move_active=0, x_lock=0.
- move_right held for 5 SCEN ticks, opponent_x=200 -> pos_x=120, move_active=1.
  - Continue to hold -> pos_x stops at 160, x_lock=1, move_active=0.
  - Then move_left for 1 tick -> pos_x=156.
- Pulse jump for 1 tick -> pos_y=384, jump_active=1; pos_y=264 after tick 16; pos_y=400 and jump_active=0 after tick 33.
  - jump held throughout does not retrigger until landing.
- Start at pos_x=102 (via moves), opponent_x=500, move_left -> pos_x=0 clamp, with no wrap.
  - Both left and right held -> pos_x unchanged, move_active=0.
- move_enable=0 or SCEN=0 with move_right and jump -> no change.
  - SCEN=0 mid-jump freezes pos_y.
  - Reset asserted mid-jump -> pos_y=400 immediately.
